// File: rtl/fb_pkg.sv
// Shared framebuffer-arbiter defaults and swap FSM encoding.
// Pure declarations; no logic.
`timescale 1ns/1ps
package fb_pkg;
  localparam int ADDR_W_DEF     = 15;
  localparam int FB_WORDS_DEF   = 23040;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PIX_W          = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    WAIT_VB = 2'd2
  } swap_state_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_dat is the head entry, zero read latency.
// Backpressure: push is ignored when full, pop is ignored when empty.
`timescale 1ns/1ps
module fb_wr_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads always win the single-port RAM, writes drain from a FIFO.
// Read latency 1 cycle; wr_ready drops while the FIFO is full or a bank swap is pending.
`timescale 1ns/1ps
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FB_WORDS   = FB_WORDS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [PIX_W-1:0]  vga_q,
  input  logic              vga_vblank,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_frame_done,
  output logic              swap_done,
  output logic              err_oob,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_q
);
  localparam int ENT_W = ADDR_W + PIX_W;
  localparam logic [ADDR_W:0] FB_LIMIT = FB_WORDS[ADDR_W:0];

  swap_state_t      state;
  swap_state_t      state_nxt;
  logic             display_bank;
  logic             vb_q;
  logic             vb_rise;
  logic             swap_fire;
  logic             rd_d1;
  logic [PIX_W-1:0] vga_q_hold;
  logic             in_range;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] pop_dat;

  assign in_range = ({1'b0, wr_addr} < FB_LIMIT);
  assign wr_ready = !fifo_full && (state == IDLE) && !reset;
  assign accept   = wr_valid && wr_ready;
  assign push     = accept && in_range;
  assign pop      = !reset && !vga_req && !fifo_empty;
  assign vb_rise  = vga_vblank && !vb_q;
  assign vga_q    = rd_d1 ? ram_q : vga_q_hold;

  fb_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat ({wr_addr, wr_data}),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Reader has absolute priority; the FIFO only gets idle RAM cycles.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      if (vga_req) begin
        ram_addr = {display_bank, vga_addr};
      end else if (pop) begin
        ram_we    = 1'b1;
        ram_addr  = {~display_bank, pop_dat[ENT_W-1:PIX_W]};
        ram_wdata = pop_dat[PIX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    swap_fire = 1'b0;
    case (state)
      IDLE:    if (wr_frame_done) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !push) state_nxt = WAIT_VB;
      WAIT_VB: begin
        if (vb_rise) begin
          state_nxt = IDLE;
          swap_fire = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // vb_q resets high so a vblank already asserted out of reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      display_bank <= 1'b0;
      vb_q         <= 1'b1;
      swap_done    <= 1'b0;
      err_oob      <= 1'b0;
      rd_d1        <= 1'b0;
      vga_q_hold   <= '0;
    end else begin
      state     <= state_nxt;
      vb_q      <= vga_vblank;
      swap_done <= swap_fire;
      rd_d1     <= vga_req;
      if (rd_d1)               vga_q_hold   <= ram_q;
      if (swap_fire)           display_bank <= ~display_bank;
      if (accept && !in_range) err_oob      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus randomized traffic against a queue/array reference model.
`timescale 1ns/1ps
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int AW    = 15;
  localparam int WORDS = 23040;
  localparam int RAM_N = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [1:0]    vga_q;
  logic          vga_vblank;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          wr_frame_done;
  logic          swap_done;
  logic          err_oob;
  logic [AW:0]   ram_addr;
  logic          ram_we;
  logic [1:0]    ram_wdata;
  logic [1:0]    ram_q;

  int checks = 0;
  int errors = 0;

  logic [1:0] ram [RAM_N];
  logic [1:0] fb  [RAM_N];

  fb_arbiter #(.ADDR_W(AW), .FB_WORDS(WORDS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .vga_req(vga_req), .vga_addr(vga_addr), .vga_q(vga_q),
    .vga_vblank(vga_vblank), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_frame_done(wr_frame_done), .swap_done(swap_done), .err_oob(err_oob),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] seed(int i);
    return 2'(i ^ (i >> 2) ^ (i >> 5));
  endfunction

  // Single-port RAM with registered read-first output.
  initial begin
    ram_q = 2'd0;
    for (int i = 0; i < RAM_N; i++) ram[i] = seed(i);
    forever begin
      @(posedge clk);
      ram_q <= ram[ram_addr];
      if (ram_we) ram[ram_addr] = ram_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0; wr_frame_done = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; vga_vblank = 0;
    vga_req = 1; vga_addr = 7; wr_valid = 1; wr_addr = 9; wr_data = 1; wr_frame_done = 1;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %0d want 0", ram_addr); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done got %b want 0", swap_done); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err_oob got %b want 0", err_oob); end
    checks++; if (vga_q !== 2'd0) begin errors++; $display("FAIL reset_vga_q got %0d want 0", vga_q); end
    checks++; if (dut.display_bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %b want 0", dut.display_bank); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
    tick();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready got %b want 1", wr_ready); end
    tick();
  endtask

  task automatic test_read();
    logic [AW-1:0] prev;
    bit have_prev = 0;
    vga_req = 1;
    for (int i = 0; i < 8; i++) begin
      vga_addr = (i < 4 || i % 2 == 0) ? AW'(5) : AW'(6);
      @(negedge clk);
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL read_ram_we cyc %0d got %b want 0", i, ram_we); end
      checks++; if (ram_addr !== {1'b0, vga_addr}) begin errors++; $display("FAIL read_ram_addr cyc %0d got %0d want %0d", i, ram_addr, vga_addr); end
      if (have_prev) begin
        checks++;
        if (vga_q !== fb[{1'b0, prev}]) begin errors++; $display("FAIL read_vga_q cyc %0d got %0d want %0d", i, vga_q, fb[{1'b0, prev}]); end
      end
      prev = vga_addr; have_prev = 1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] a [5];
    logic [1:0]    d [5];
    vga_vblank = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a[i] = AW'($urandom_range(0, WORDS - 1));
      d[i] = 2'($urandom);
    end
    vga_req = 1; vga_addr = 0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = a[i]; wr_data = d[i];
      @(negedge clk);
      checks++; if (wr_ready !== (i < 4)) begin errors++; $display("FAIL full_wr_ready cyc %0d got %b want %b", i, wr_ready, i < 4); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL full_ram_we cyc %0d got %b want 0", i, ram_we); end
      if (i == 4) begin
        checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", dut.u_fifo.count); end
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      vga_req = 0; wr_valid = (k < 2); wr_addr = a[4]; wr_data = d[4];
      @(negedge clk);
      if (k < 2) begin
        checks++; if (wr_ready !== (k == 1)) begin errors++; $display("FAIL full_pop_ready cyc %0d got %b want %b", k, wr_ready, k == 1); end
      end
      if (k == 2) begin
        checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL pushpop_count got %0d want 3", dut.u_fifo.count); end
      end
      checks++; if (ram_we !== (k < 5)) begin errors++; $display("FAIL drain_ram_we cyc %0d got %b want %b", k, ram_we, k < 5); end
      if (k < 5) begin
        checks++;
        if (ram_addr !== {1'b1, a[k]} || ram_wdata !== d[k]) begin
          errors++; $display("FAIL drain_write cyc %0d got %0d/%0d want %0d/%0d", k, ram_addr, ram_wdata, {1'b1, a[k]}, d[k]);
        end
        fb[{1'b1, a[k]}] = d[k];
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_swap();
    int pulses = 0;
    vga_vblank = 0;
    do_reset();
    wr_valid = 1; wr_addr = 100; wr_data = 3;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL swap_wr_ready got %b want 1", wr_ready); end
    tick();
    wr_valid = 0; wr_frame_done = 1;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h8064 || ram_wdata !== 2'd3) begin
      errors++; $display("FAIL swap_write got we=%b %0d/%0d want we=1 %0d/3", ram_we, ram_addr, ram_wdata, 16'h8064);
    end
    fb[{1'b1, 15'd100}] = 2'd3;
    tick();
    wr_frame_done = 0;
    repeat (3) tick();
    wr_frame_done = 1;
    tick();
    wr_frame_done = 0;
    @(negedge clk);
    checks++; if (dut.state !== WAIT_VB) begin errors++; $display("FAIL swap_wait_state got %0d want %0d", dut.state, WAIT_VB); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL swap_wait_ready got %b want 0", wr_ready); end
    tick();
    vga_vblank = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (swap_done === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL swap_pulses got %0d want 1", pulses); end
    checks++; if (dut.display_bank !== 1'b1) begin errors++; $display("FAIL swap_bank got %b want 1", dut.display_bank); end
    vga_req = 1; vga_addr = 100;
    tick();
    vga_req = 0;
    @(negedge clk);
    checks++; if (vga_q !== 2'd3) begin errors++; $display("FAIL swap_readback got %0d want 3", vga_q); end
    tick();
    vga_vblank = 0;
  endtask

  task automatic test_oob();
    vga_vblank = 0;
    do_reset();
    wr_valid = 1; wr_addr = AW'(WORDS); wr_data = 2;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready got %b want 1", wr_ready); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_early got %b want 0", err_oob); end
    tick();
    wr_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL oob_ram_we cyc %0d got %b want 0", i, ram_we); end
      checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_flag cyc %0d got %b want 1", i, err_oob); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready_after cyc %0d got %b want 1", i, wr_ready); end
      tick();
    end
    wr_valid = 1; wr_addr = AW'(WORDS - 1); wr_data = 1;
    tick();
    wr_valid = 0;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_addr !== {1'b1, AW'(WORDS - 1)} || ram_wdata !== 2'd1) begin
      errors++; $display("FAIL oob_last_word got we=%b %0d/%0d want we=1 %0d/1", ram_we, ram_addr, ram_wdata, {1'b1, AW'(WORDS - 1)});
    end
    fb[{1'b1, AW'(WORDS - 1)}] = 2'd1;
    tick();
    do_reset();
    @(negedge clk);
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_cleared got %b want 0", err_oob); end
    tick();
  endtask

  task automatic test_drain_in_vblank();
    logic [AW-1:0] a [2];
    logic [1:0]    d [2];
    int nw = 0;
    int pulses = 0;
    bit found = 0;
    vga_vblank = 1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      a[i] = AW'($urandom_range(0, WORDS - 1));
      d[i] = 2'($urandom);
    end
    vga_req = 1; vga_addr = 3;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_addr = a[i]; wr_data = d[i]; wr_frame_done = (i == 1);
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL vbd_ready cyc %0d got %b want 1", i, wr_ready); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        if (nw < 2) begin
          checks++;
          if (ram_addr !== {1'b1, a[nw]} || ram_wdata !== d[nw]) begin
            errors++; $display("FAIL vbd_write %0d got %0d/%0d want %0d/%0d", nw, ram_addr, ram_wdata, {1'b1, a[nw]}, d[nw]);
          end
          fb[{1'b1, a[nw]}] = d[nw];
        end
        nw++;
      end
      if (swap_done === 1'b1) pulses++;
      tick();
    end
    checks++; if (nw != 2) begin errors++; $display("FAIL vbd_write_count got %0d want 2", nw); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL vbd_early_swap got %0d want 0", pulses); end
    checks++; if (dut.state !== WAIT_VB) begin errors++; $display("FAIL vbd_state got %0d want %0d", dut.state, WAIT_VB); end
    vga_vblank = 0;
    repeat (3) tick();
    vga_vblank = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (swap_done === 1'b1) found = 1;
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL vbd_swap_timeout got none want 1 pulse"); end
    checks++; if (dut.display_bank !== 1'b1) begin errors++; $display("FAIL vbd_bank got %b want 1", dut.display_bank); end
    vga_vblank = 0;
  endtask

  task automatic test_reset_in_drain();
    bit found = 0;
    vga_vblank = 0;
    do_reset();
    wr_frame_done = 1;
    tick();
    wr_frame_done = 0;
    repeat (2) tick();
    vga_vblank = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (swap_done === 1'b1) found = 1;
      tick();
    end
    checks++; if (!found || dut.display_bank !== 1'b1) begin errors++; $display("FAIL rid_preswap got bank %b want 1", dut.display_bank); end
    vga_vblank = 0;
    vga_req = 1; vga_addr = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = AW'(200 + i); wr_data = 2'(i + 1); wr_frame_done = (i == 2);
      tick();
    end
    wr_valid = 0; wr_frame_done = 0;
    @(negedge clk);
    checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL rid_state_drain got %0d want %0d", dut.state, DRAIN); end
    checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL rid_count got %0d want 3", dut.u_fifo.count); end
    tick();
    reset = 1; vga_req = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rid_ram_we cyc %0d got %b want 0", i, ram_we); end
      tick();
      if (i == 1) reset = 0;
    end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rid_state got %0d want %0d", dut.state, IDLE); end
    checks++; if (dut.display_bank !== 1'b0) begin errors++; $display("FAIL rid_bank got %b want 0", dut.display_bank); end
  endtask

  task automatic test_random();
    logic [AW:0] pend_a [$];
    logic [1:0]  pend_d [$];
    logic [AW-1:0] prev_addr = '0;
    bit prev_rd = 0;
    bit oob_seen = 0;
    bit rdy_exp;
    bit we_exp;
    vga_vblank = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      vga_req  = ($urandom_range(0, 2) == 0);
      vga_addr = AW'($urandom_range(0, WORDS - 1));
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(WORDS, (1 << AW) - 1))
                                            : AW'($urandom_range(0, WORDS - 1));
      wr_data  = 2'($urandom);
      @(negedge clk);
      rdy_exp = pend_a.size() < 4;
      we_exp  = !vga_req && pend_a.size() > 0;
      checks++; if (wr_ready !== rdy_exp) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, wr_ready, rdy_exp); end
      checks++; if (ram_we !== we_exp) begin errors++; $display("FAIL rnd_we cyc %0d got %b want %b", c, ram_we, we_exp); end
      if (we_exp) begin
        checks++;
        if (ram_addr !== pend_a[0] || ram_wdata !== pend_d[0]) begin
          errors++; $display("FAIL rnd_write cyc %0d got %0d/%0d want %0d/%0d", c, ram_addr, ram_wdata, pend_a[0], pend_d[0]);
        end
        fb[pend_a[0]] = pend_d[0];
        void'(pend_a.pop_front());
        void'(pend_d.pop_front());
      end else if (vga_req) begin
        checks++; if (ram_addr !== {1'b0, vga_addr}) begin errors++; $display("FAIL rnd_rd_addr cyc %0d got %0d want %0d", c, ram_addr, vga_addr); end
      end
      if (prev_rd) begin
        checks++; if (vga_q !== fb[{1'b0, prev_addr}]) begin errors++; $display("FAIL rnd_vga_q cyc %0d got %0d want %0d", c, vga_q, fb[{1'b0, prev_addr}]); end
      end
      checks++; if (err_oob !== oob_seen) begin errors++; $display("FAIL rnd_oob cyc %0d got %b want %b", c, err_oob, oob_seen); end
      if (wr_valid && rdy_exp) begin
        if (int'(wr_addr) < WORDS) begin
          pend_a.push_back({1'b1, wr_addr});
          pend_d.push_back(wr_data);
        end else begin
          oob_seen = 1;
        end
      end
      prev_rd = vga_req; prev_addr = vga_addr;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < RAM_N; i++) fb[i] = seed(i);
    test_reset();
    test_read();
    test_fifo_full();
    test_swap();
    test_oob();
    test_drain_in_vblank();
    test_reset_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
